// File: rtl/prewish_button_poller.sv
// prewish_button_poller: polls the debouncer over a strobe/data handshake and turns each
// returned status byte into held button levels plus one-cycle press/release pulses.
module prewish_button_poller #(
  parameter int POLL_DIV   = 1000,
  parameter int STB_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  output logic       STB_O,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  input  logic       i_poll_now,
  input  logic       i_clr_err,
  output logic [7:0] o_buttons,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic       o_valid,
  output logic       o_timeout,
  output logic [7:0] o_timeouts
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int SW = (STB_CYCLES > 1) ? $clog2(STB_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(STB_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic [PW-1:0] pcnt_q,     pcnt_d;
  logic [SW-1:0] scnt_q,     scnt_d;
  logic [TW-1:0] tcnt_q,     tcnt_d;
  logic          stb_q,      stb_d;
  logic          primed_q,   primed_d;
  logic [7:0]    buttons_q,  buttons_d;
  logic [7:0]    pressed_q,  pressed_d;
  logic [7:0]    released_q, released_d;
  logic          valid_q,    valid_d;
  logic          timeout_q,  timeout_d;
  logic [7:0]    timeouts_q, timeouts_d;
  logic          capture_s;
  logic          expire_s;

  // The poll counter only runs in IDLE, so the poll period stretches by the handshake time.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    scnt_d    = scnt_q;
    tcnt_d    = tcnt_q;
    stb_d     = stb_q;
    capture_s = 1'b0;
    expire_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_poll_now || (pcnt_q == POLL_LAST)) begin
          pcnt_d  = '0;
          scnt_d  = '0;
          stb_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      ST_REQ: begin
        if (scnt_q == STB_LAST) begin
          stb_d   = 1'b0;
          tcnt_d  = '0;
          state_d = ST_WAIT;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      ST_WAIT: begin
        // A response on the final WAIT cycle still counts as an answer.
        if (STB_I) begin
          capture_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (tcnt_q == TO_LAST) begin
          expire_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        stb_d   = 1'b0;
        pcnt_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    primed_d   = primed_q;
    buttons_d  = buttons_q;
    pressed_d  = 8'h00;
    released_d = 8'h00;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    timeouts_d = timeouts_q;
    if (capture_s) begin
      // Edges are meaningless until a first sample exists to compare against.
      if (primed_q) begin
        pressed_d  = DAT_I & ~buttons_q;
        released_d = ~DAT_I & buttons_q;
      end else begin
        pressed_d  = 8'h00;
        released_d = 8'h00;
      end
      buttons_d = DAT_I;
      valid_d   = 1'b1;
      primed_d  = 1'b1;
    end else begin
      buttons_d = buttons_q;
    end
    if (i_clr_err) begin
      timeout_d  = 1'b0;
      timeouts_d = 8'h00;
    end else if (expire_s) begin
      timeout_d = 1'b1;
      if (timeouts_q != 8'hFF) begin
        timeouts_d = timeouts_q + 8'd1;
      end else begin
        timeouts_d = timeouts_q;
      end
    end else begin
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q    <= ST_IDLE;
      pcnt_q     <= '0;
      scnt_q     <= '0;
      tcnt_q     <= '0;
      stb_q      <= 1'b0;
      primed_q   <= 1'b0;
      buttons_q  <= 8'h00;
      pressed_q  <= 8'h00;
      released_q <= 8'h00;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      timeouts_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      scnt_q     <= scnt_d;
      tcnt_q     <= tcnt_d;
      stb_q      <= stb_d;
      primed_q   <= primed_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      timeouts_q <= timeouts_d;
    end
  end

  assign STB_O      = stb_q;
  assign o_buttons  = buttons_q;
  assign o_pressed  = pressed_q;
  assign o_released = released_q;
  assign o_valid    = valid_q;
  assign o_timeout  = timeout_q;
  assign o_timeouts = timeouts_q;

endmodule
